draw_port_arbiter: RTL
======================

# draw_port_arbiter

Round-robin arbiter and sequencer for the single VGA adapter write port. Screen, maze and sprite drawers (e.g. the full-screen start/game-over/winner/clear painter) each request the port. The arbiter grants one drawer at a time and forwards that drawer's x/y/colour stream as registered plot commands. A grant is held until the owner signals done, the owner withdraws its request, or an optional watchdog expires.

## Interface
Parameters:
- NREQ, 4, number of requesting drawers (2..8)
- TIMEOUT, 60000, watchdog limit in grant cycles; covers a 240x240 fill plus margin

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- req  in  NREQ  per-drawer request level
- src_x  in  NREQ*9  packed x locations; drawer i at [9i+8:9i]
- src_y  in  NREQ*9  packed y locations; same packing as src_x
- src_colour  in  NREQ*3  packed colours; drawer i at [3i+2:3i]
- src_done  in  NREQ  per-drawer completion pulse
- gnt  out  NREQ  one-hot grant, registered
- vga_x  out  9  plot x, registered
- vga_y  out  9  plot y, registered
- vga_colour  out  3  plot colour, registered
- vga_plot  out  1  write enable to the VGA adapter
- busy  out  1  high in every state except IDLE
- timeout  out  1  one-cycle pulse on a watchdog release

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE → GRANT when req is non-zero.
  - The winner is the first set req bit searching upward (with wrap) from last+1.
  - On that transition, gnt[winner] is set and last is updated to winner.
- GRANT:
  - Each cycle, vga_x/vga_y/vga_colour are loaded from the granted drawer's slices.
  - vga_plot is set to 1 unless src_done[g] is high that cycle.
- GRANT → RELEASE on the first of:
  - src_done[g]=1
  - req[g]=0 (abort)
  - the watchdog limit (when compiled in)
- RELEASE:
  - gnt=0, vga_plot=0, vga_x/vga_y/vga_colour=0.
  - Unconditionally returns to IDLE next cycle.
  - This guarantees at least one idle cycle between owners.
- src_done or req activity from non-granted drawers is ignored.
- Simultaneous requests are served in rotation; no drawer is granted twice while another is waiting.
- Reset values:
  - Outputs: gnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, timeout=0.
  - Internal: state=IDLE, last=NREQ-1, so drawer 0 wins first after reset.
- Reset mid-grant: all outputs return to their reset values on the next edge; no plot is issued after reset.

## Timing
- Grant latency: req rises at edge k → gnt at edge k+1 (from IDLE).
- Plot latency: source values sampled at edge n appear on vga_* after edge n.
  - First vga_plot=1 occurs one cycle after gnt rises.
  - Drawers must present their first pixel while seeing gnt.
- The done cycle is not plotted; drawers may drive don't-care coordinates with done.
- Back-to-back ownership costs 3 cycles: GRANT→RELEASE, RELEASE→IDLE, IDLE→GRANT.
- Watchdog:
  - 17-bit counter, cleared on entry to GRANT, incremented each GRANT cycle.
  - At count==TIMEOUT-1, forces RELEASE and pulses timeout in the RELEASE cycle.

## Configuration
- DRAW_ARB_TIMEOUT_EN defined: watchdog counter and timeout pulse are present, as described above.
- Not defined:
  - No counter is built and timeout is tied to 0.
  - A grant ends only on src_done or request withdrawal.

## Structure
- Shared package draw_arb_pkg holds:
  - state enum (IDLE, GRANT, RELEASE)
  - X_W=9, Y_W=9, C_W=3
  - default TIMEOUT constant
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: winner index and valid.
- Both the top-level FSM and the output registers stay in draw_port_arbiter.

## Test plan
- Single requester: req=0001, drawer 0 streams (80,0),(81,0),(82,0) colour 3'b001, then done → gnt=0001 one cycle after req; three vga_plot pulses with matching coordinates; gnt=0 in RELEASE.
- Simultaneous req=1111 after reset, each drawer does 2 pixels then done → grants in order 0,1,2,3; each handover has a ≥1-cycle vga_plot=0 gap.
- Rotation fairness: drawer 0 re-requests immediately while drawer 2 waits → drawer 2 granted before drawer 0 again.
- Abort: drawer 1 drops req mid-grant after 5 pixels → RELEASE next cycle; no further plots from drawer 1; src_done from drawer 3 during this grant is ignored.
- Watchdog (macro defined, TIMEOUT=16): drawer 2 never asserts done → exactly 16 GRANT cycles, then one timeout pulse, gnt=0; with macro undefined, gnt stays 0100 indefinitely.
- Reset mid-grant: resetn=0 during a drawer 0 stream → all outputs 0 next edge; after release, req=1111 grants drawer 0 first.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// draw_arb_pkg: shared types and constants for the VGA draw-port arbiter
// Contents: FSM state enum, pixel field widths, watchdog counter width and default limit.
package draw_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    localparam int X_W = 9;
    localparam int Y_W = 9;
    localparam int C_W = 3;
    localparam int WD_W = 17;
    localparam int TIMEOUT_DEF = 60000;
endpackage

// File: rtl/draw_port_arbiter_if.sv
// draw_port_arbiter_if: bundle between the drawers and the VGA write-port arbiter
// Signals: req, src_x/src_y/src_colour (packed per drawer), src_done  -> arbiter
//          gnt, vga_x/vga_y/vga_colour, vga_plot, busy, timeout       <- arbiter
// Modports: master = drawer side, slave = arbiter side.
interface draw_port_arbiter_if import draw_arb_pkg::*; #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0] req;
    logic [NREQ*X_W-1:0] src_x;
    logic [NREQ*Y_W-1:0] src_y;
    logic [NREQ*C_W-1:0] src_colour;
    logic [NREQ-1:0] src_done;
    logic [NREQ-1:0] gnt;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic vga_plot;
    logic busy;
    logic timeout;
    modport master (
        output req, src_x, src_y, src_colour, src_done,
        input gnt, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
    );
    modport slave (
        input req, src_x, src_y, src_colour, src_done,
        output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
// Ports: req (request levels), last (previous winner) -> winner (first set bit
//        searching upward from last+1 with wrap), valid (any request set).
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input logic [NREQ-1:0] req,
    input logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic valid
);
    assign valid = |req;
    // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
    always_comb begin
        winner = '0;
        for (int i = NREQ; i >= 1; i--)
            if (req[(int'(last) + i) % NREQ])
                winner = IW'((int'(last) + i) % NREQ);
    end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin owner of the single VGA write port
// Ports: clk, resetn (synchronous, active-low), bus (draw_port_arbiter_if.slave):
//        per-drawer req/src_*/src_done in, registered one-hot gnt and plot command out,
//        busy (not IDLE), timeout (one-cycle pulse on a watchdog release).
// Build option: define DRAW_ARB_TIMEOUT_EN to add the grant watchdog; without it
//        a grant ends only on src_done or request withdrawal and timeout stays 0.
module draw_port_arbiter import draw_arb_pkg::*; #(
    parameter int NREQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int IW = $clog2(NREQ)
) (
    input logic clk,
    input logic resetn,
    draw_port_arbiter_if.slave bus
);
    state_t state;
    logic [IW-1:0] last, g, winner;
    logic valid, wd_hit, done_g, req_g, leave;
    assign done_g = bus.src_done[g];
    assign req_g = bus.req[g];
    assign leave = done_g || !req_g || wd_hit;
    assign bus.busy = state != IDLE;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req(bus.req),
        .last(last),
        .winner(winner),
        .valid(valid)
    );
`ifdef DRAW_ARB_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;
    assign wd_hit = wd_cnt == WD_W'(TIMEOUT - 1);
    // Held at zero outside GRANT so every grant starts counting from 0.
    always_ff @(posedge clk)
        wd_cnt <= (!resetn || state != GRANT) ? '0 : wd_cnt + 1'b1;
`else
    assign wd_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            last <= IW'(NREQ - 1);
            g <= '0;
            bus.gnt <= '0;
            bus.vga_x <= '0;
            bus.vga_y <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: if (valid) begin
                    state <= GRANT;
                    g <= winner;
                    last <= winner;
                    bus.gnt <= NREQ'(1) << winner;
                end
                GRANT: if (leave) begin
                    // RELEASE values land on the leaving edge, so the done/abort cycle is never plotted.
                    state <= RELEASE;
                    bus.gnt <= '0;
                    bus.vga_x <= '0;
                    bus.vga_y <= '0;
                    bus.vga_colour <= '0;
                    bus.vga_plot <= 1'b0;
                    bus.timeout <= wd_hit && !done_g && req_g;
                end else begin
                    bus.vga_x <= bus.src_x[g*X_W +: X_W];
                    bus.vga_y <= bus.src_y[g*Y_W +: Y_W];
                    bus.vga_colour <= bus.src_colour[g*C_W +: C_W];
                    bus.vga_plot <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
